ysyx_22040127_rf_wb_arbiter: RTL and testbench

//  Owns the single register-file write port and shares it between two writeback requesters: EXU (ALU/CSR results) and LSU (load data).

---
 rtl/ysyx_22040127_rf_wb_arbiter_pkg.sv | 22 ++
 rtl/ysyx_22040127_rf_wb_arbiter_if.sv | 49 ++++
 rtl/ysyx_22040127_rr_arb2.sv | 34 +++
 rtl/ysyx_22040127_rf_wb_arbiter.sv | 107 ++++++++++
 tb/tb_ysyx_22040127_rf_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040127_rf_wb_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040127_rf_pkg : shared constants and writeback request type       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ysyx_22040127_rf_pkg;
  localparam int GPR_AW = 5;
  localparam int GPR_DW = 64;

  // Requester ids double as bit positions in request/grant vectors.
  localparam logic REQ_EXU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [GPR_AW-1:0] rd;
    logic [GPR_DW-1:0] data;
  } wb_req_t;
endpackage

`default_nettype wire

// File: rtl/ysyx_22040127_rf_wb_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040127_rf_wb_arbiter_if : issue/decode/writeback/RF port bundle   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ysyx_22040127_rf_wb_arbiter_if
  import ysyx_22040127_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_AW,
  parameter int DATA_WIDTH = GPR_DW
);
  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_ready;
  logic [ADDR_WIDTH-1:0] dec_rs1;
  logic [ADDR_WIDTH-1:0] dec_rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  exu_valid;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;
  logic                  exu_ready;
  logic                  lsu_valid;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;
  logic                  flush;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  sb_err;

  modport master (
    output iss_valid, iss_rd, dec_rs1, dec_rs2,
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data, flush,
    input  iss_ready, rs1_busy, rs2_busy, exu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata, sb_err
  );

  modport slave (
    input  iss_valid, iss_rd, dec_rs1, dec_rs2,
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data, flush,
    output iss_ready, rs1_busy, rs2_busy, exu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata, sb_err
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22040127_rr_arb2.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040127_rr_arb2 : 2-way round-robin arbiter with pointer flop      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ysyx_22040127_rr_arb2
  import ysyx_22040127_rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic rr_ptr;

  // rr_ptr names the requester that wins a tie.
  always_comb begin
    gnt = 2'b00;
    if (req[REQ_EXU] && req[REQ_LSU])
      gnt[rr_ptr] = 1'b1;
    else
      gnt = req;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      rr_ptr <= REQ_EXU;
    else if (|gnt)
      rr_ptr <= gnt[REQ_EXU] ? REQ_LSU : REQ_EXU;
  end
endmodule

`default_nettype wire

// File: rtl/ysyx_22040127_rf_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040127_rf_wb_arbiter : RF write-port arbiter + GPR busy scoreboard|
// | Option: YSYX_22040127_WB_BYPASS_EN forwards same-cycle writes to decode. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ysyx_22040127_rf_wb_arbiter
  import ysyx_22040127_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_AW,
  parameter int DATA_WIDTH = GPR_DW
)
(
  input logic clk,
  input logic rst,
  ysyx_22040127_rf_wb_arbiter_if.slave bus
);
  localparam int NREG = 1 << ADDR_WIDTH;

  wb_req_t               exu_req;
  wb_req_t               lsu_req;
  wb_req_t               win;
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  wb_nz;
  logic                  iss_ok;
  logic                  iss_fire;
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic                  sb_err_q;

  assign exu_req = '{valid: bus.exu_valid, rd: bus.exu_rd, data: bus.exu_data};
  assign lsu_req = '{valid: bus.lsu_valid, rd: bus.lsu_rd, data: bus.lsu_data};

  assign req[REQ_EXU] = exu_req.valid;
  assign req[REQ_LSU] = lsu_req.valid;

  ysyx_22040127_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  // Winner mux; an idle cycle presents all-zero fields on the write port.
  always_comb begin
    win = '0;
    if (gnt[REQ_EXU])
      win = exu_req;
    else if (gnt[REQ_LSU])
      win = lsu_req;
  end

  assign win_rd   = win.rd;
  assign win_data = win.data;
  assign wb_nz    = win.valid && (win_rd != '0);

  assign bus.exu_ready = gnt[REQ_EXU];
  assign bus.lsu_ready = gnt[REQ_LSU];
  assign bus.rf_wen    = wb_nz;
  assign bus.rf_waddr  = win_rd;
  assign bus.rf_wdata  = win_data;

  assign iss_ok        = !bus.iss_valid || (bus.iss_rd == '0) || !busy[bus.iss_rd];
  assign iss_fire      = bus.iss_valid && iss_ok && (bus.iss_rd != '0);
  assign bus.iss_ready = iss_ok;

  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_nz)
        busy_nxt[win_rd] = 1'b0;
      if (iss_fire)
        busy_nxt[bus.iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (wb_nz && !busy[win_rd] && !bus.flush)
        sb_err_q <= 1'b1;
    end
  end

  assign bus.sb_err = sb_err_q;

`ifdef YSYX_22040127_WB_BYPASS_EN
  // Decode picks up rf_wdata in the same cycle, so a matching write hides the hazard.
  assign bus.rs1_busy = busy[bus.dec_rs1] && !(wb_nz && (win_rd == bus.dec_rs1));
  assign bus.rs2_busy = busy[bus.dec_rs2] && !(wb_nz && (win_rd == bus.dec_rs2));
`else
  assign bus.rs1_busy = busy[bus.dec_rs1];
  assign bus.rs2_busy = busy[bus.dec_rs2];
`endif
endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040127_rf_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_ysyx_22040127_rf_wb_arbiter : directed + random bench with set model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_22040127_rf_wb_arbiter;
  import ysyx_22040127_rf_pkg::*;

`ifdef YSYX_22040127_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  ysyx_22040127_rf_wb_arbiter_if bif ();

  ysyx_22040127_rf_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: set of registers with an outstanding write, tie preference, sticky error.
  bit pend [32];
  bit prefer_lsu;
  bit sberr;
  bit last_eg;
  bit last_lg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    prefer_lsu = 1'b0;
    sberr      = 1'b0;
  endtask

  task automatic idle();
    bif.iss_valid = 1'b0; bif.iss_rd  = 5'd0;
    bif.dec_rs1   = 5'd0; bif.dec_rs2 = 5'd0;
    bif.exu_valid = 1'b0; bif.exu_rd  = 5'd0; bif.exu_data = 64'd0;
    bif.lsu_valid = 1'b0; bif.lsu_rd  = 5'd0; bif.lsu_data = 64'd0;
    bif.flush     = 1'b0;
  endtask

  function automatic bit exp_busy(input logic [4:0] rs, input bit wen, input logic [4:0] wa);
    return pend[rs] && !(BYPASS && wen && (wa == rs));
  endfunction

  // Called just after a negedge with inputs applied: check outputs, then advance one clock.
  task automatic step();
    bit          eg, lg, wv, wen, iok;
    logic [4:0]  wrd;
    logic [63:0] wdat;
    #1;
    eg   = bif.exu_valid && (!bif.lsu_valid || !prefer_lsu);
    lg   = bif.lsu_valid && !eg;
    wv   = eg || lg;
    wrd  = eg ? bif.exu_rd   : (lg ? bif.lsu_rd   : 5'd0);
    wdat = eg ? bif.exu_data : (lg ? bif.lsu_data : 64'd0);
    wen  = wv && (wrd != 5'd0);
    iok  = !bif.iss_valid || (bif.iss_rd == 5'd0) || !pend[bif.iss_rd];
    chk("exu_ready", bif.exu_ready, eg);
    chk("lsu_ready", bif.lsu_ready, lg);
    chk("rf_wen",    bif.rf_wen,    wen);
    chk("rf_waddr",  bif.rf_waddr,  wrd);
    chk("rf_wdata",  bif.rf_wdata,  wdat);
    chk("iss_ready", bif.iss_ready, iok);
    chk("rs1_busy",  bif.rs1_busy,  exp_busy(bif.dec_rs1, wen, wrd));
    chk("rs2_busy",  bif.rs2_busy,  exp_busy(bif.dec_rs2, wen, wrd));
    chk("sb_err",    bif.sb_err,    sberr);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (wen && !pend[wrd] && !bif.flush) sberr = 1'b1;
      if (wv) prefer_lsu = eg;
      if (bif.flush) begin
        foreach (pend[i]) pend[i] = 1'b0;
      end else begin
        if (wen) pend[wrd] = 1'b0;
        if (iok && bif.iss_valid && bif.iss_rd != 5'd0) pend[bif.iss_rd] = 1'b1;
      end
    end
    last_eg = eg;
    last_lg = lg;
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    for (int k = 0; k < 8; k++) begin
      r = 5'($urandom_range(1, 7));
      if (pend[r]) return r;
    end
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    bit          ev, lv;
    logic [4:0]  erd, lrd;
    logic [63:0] edat, ldat;
    logic [4:0]  ex_r, ls_r;

    // 1: reset
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    #1;
    chk("rst_rf_wen", bif.rf_wen, 1'b0);
    chk("rst_sb_err", bif.sb_err, 1'b0);
    chk("rst_iss_ready", bif.iss_ready, 1'b1);
    for (int i = 0; i < 32; i++) begin
      bif.dec_rs1 = 5'(i);
      bif.dec_rs2 = 5'(31 - i);
      #1;
      chk("rst_rs1_busy", bif.rs1_busy, 1'b0);
      chk("rst_rs2_busy", bif.rs2_busy, 1'b0);
    end
    @(negedge clk);
    idle();
    rst = 1'b1;

    // 2: issue, RAW, WAW block, writeback
    bif.iss_valid = 1'b1; bif.iss_rd = 5'd5;
    step();
    idle(); bif.dec_rs1 = 5'd5;
    #1 chk("t2_rs1_busy", bif.rs1_busy, 1'b1);
    step();
    bif.iss_valid = 1'b1; bif.iss_rd = 5'd5;
    #1 chk("t2_waw_block", bif.iss_ready, 1'b0);
    step();
    idle(); bif.exu_valid = 1'b1; bif.exu_rd = 5'd5; bif.exu_data = 64'h1234;
    #1;
    chk("t2_rf_wen", bif.rf_wen, 1'b1);
    chk("t2_rf_waddr", bif.rf_waddr, 5'd5);
    chk("t2_rf_wdata", bif.rf_wdata, 64'h1234);
    step();
    idle(); bif.dec_rs1 = 5'd5;
    #1 chk("t2_rs1_clear", bif.rs1_busy, 1'b0);
    step();

    // 3: both requesters every cycle, fresh pre-issued rd per grant
    for (int r = 1; r <= 6; r++) begin
      idle(); bif.iss_valid = 1'b1; bif.iss_rd = 5'(r);
      step();
    end
    idle();
    ex_r = 5'd1; ls_r = 5'd2;
    bif.exu_data = {$urandom, $urandom};
    bif.lsu_data = {$urandom, $urandom};
    for (int c = 0; c < 6; c++) begin
      bif.exu_valid = 1'b1; bif.exu_rd = ex_r;
      bif.lsu_valid = 1'b1; bif.lsu_rd = ls_r;
      step();
      if (last_eg) begin ex_r = ex_r + 5'd2; bif.exu_data = {$urandom, $urandom}; end
      if (last_lg) begin ls_r = ls_r + 5'd2; bif.lsu_data = {$urandom, $urandom}; end
    end
    chk("t3_exu_grants", ex_r, 5'd7);
    chk("t3_lsu_grants", ls_r, 5'd8);

    // 4: rd==0 issue and writeback
    idle(); bif.iss_valid = 1'b1; bif.iss_rd = 5'd0;
    #1 chk("t4_iss_ready", bif.iss_ready, 1'b1);
    step();
    idle(); bif.lsu_valid = 1'b1; bif.lsu_rd = 5'd0; bif.lsu_data = 64'hdead;
    #1;
    chk("t4_lsu_ready", bif.lsu_ready, 1'b1);
    chk("t4_rf_wen", bif.rf_wen, 1'b0);
    step();
    idle();
    #1 chk("t4_sb_err", bif.sb_err, 1'b0);

    // 5: flush with concurrent issue and writeback
    bif.iss_valid = 1'b1; bif.iss_rd = 5'd3; step();
    bif.iss_rd = 5'd7; step();
    idle(); bif.flush = 1'b1; bif.iss_valid = 1'b1; bif.iss_rd = 5'd9;
    bif.exu_valid = 1'b1; bif.exu_rd = 5'd3; bif.exu_data = 64'h33;
    #1;
    chk("t5_rf_wen", bif.rf_wen, 1'b1);
    chk("t5_rf_waddr", bif.rf_waddr, 5'd3);
    step();
    idle(); bif.dec_rs1 = 5'd7; bif.dec_rs2 = 5'd9;
    #1;
    chk("t5_rs1_flushed", bif.rs1_busy, 1'b0);
    chk("t5_rs2_flushed", bif.rs2_busy, 1'b0);
    chk("t5_sb_err", bif.sb_err, 1'b0);
    step();
    idle(); bif.exu_valid = 1'b1; bif.exu_rd = 5'd7; bif.exu_data = 64'h77;
    step();
    idle();
    #1 chk("t5_sb_err_set", bif.sb_err, 1'b1);

    // 6: same-cycle forward
    bif.iss_valid = 1'b1; bif.iss_rd = 5'd4; step();
    idle(); bif.exu_valid = 1'b1; bif.exu_rd = 5'd4; bif.exu_data = 64'h44; bif.dec_rs2 = 5'd4;
    #1 chk("t6_rs2_bypass", bif.rs2_busy, BYPASS ? 1'b0 : 1'b1);
    step();

    // Reset mid-operation
    idle(); bif.iss_valid = 1'b1; bif.iss_rd = 5'd6; step();
    rst = 1'b0; bif.exu_valid = 1'b1; bif.exu_rd = 5'd6; bif.lsu_valid = 1'b1; bif.lsu_rd = 5'd2;
    step();
    rst = 1'b1; idle(); bif.dec_rs1 = 5'd6;
    #1;
    chk("rst2_sb_err", bif.sb_err, 1'b0);
    chk("rst2_rs1_busy", bif.rs1_busy, 1'b0);
    step();

    // Random traffic
    ev = 1'b0; lv = 1'b0; erd = 5'd0; lrd = 5'd0; edat = 64'd0; ldat = 64'd0;
    for (int n = 0; n < 400; n++) begin
      if (!ev && $urandom_range(0, 1) == 1) begin ev = 1'b1; erd = pick_rd(); edat = {$urandom, $urandom}; end
      if (!lv && $urandom_range(0, 1) == 1) begin lv = 1'b1; lrd = pick_rd(); ldat = {$urandom, $urandom}; end
      bif.exu_valid = ev; bif.exu_rd = erd; bif.exu_data = edat;
      bif.lsu_valid = lv; bif.lsu_rd = lrd; bif.lsu_data = ldat;
      bif.iss_valid = 1'($urandom_range(0, 1));
      bif.iss_rd    = 5'($urandom_range(0, 7));
      bif.dec_rs1   = 5'($urandom_range(0, 7));
      bif.dec_rs2   = 5'($urandom_range(0, 7));
      bif.flush     = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 99) != 0);
      step();
      if (last_eg) ev = 1'b0;
      if (last_lg) lv = 1'b0;
    end
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
